uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Control and buffering wrapper around the UART receiver. It owns the receiver configuration (par_en, par_typ, prescale) and applies host config changes only between frames, never mid-frame. It tracks frame activity on the serial line with a timeout watchdog. Good bytes go into a first-word-fall-through FIFO for the host; parity, stop and overflow events are counted.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
CNT_W, 8, width of each saturating error counter
RST_PAR_EN, 1, par_en value after reset
RST_PAR_TYP, 0, par_typ value after reset (0 even, 1 odd)
RST_PRESCALE, 8, prescale value after reset

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
rx_in  in  1  serial line, monitored in parallel with the receiver
rx_p_data  in  8  receiver parallel data
rx_data_valid  in  1  receiver good-frame flag
rx_par_err  in  1  receiver parity error flag
rx_stp_err  in  1  receiver stop error flag
cfg_req  in  1  one-cycle pulse: request new config
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type
cfg_prescale  in  6  requested oversampling ratio (legal values 8, 16, 32)
cfg_ack  out  1  one-cycle pulse: config applied
par_en  out  1  to receiver PAR_EN
par_typ  out  1  to receiver PAR_TYP
prescale  out  6  to receiver prescale
rd_valid  out  1  FIFO not empty
rd_data  out  8  FIFO head (valid when rd_valid)
rd_en  in  1  pop head; ignored when rd_valid=0
par_err_cnt  out  CNT_W  parity errors
stp_err_cnt  out  CNT_W  stop errors
ovf_cnt  out  CNT_W  good bytes dropped because FIFO full
tmo_cnt  out  CNT_W  frames ended by watchdog
cnt_clr  in  1  synchronous clear of all four counters

Behaviour:
- Reset (rst=1 at a clock edge):
  - par_en=RST_PAR_EN, par_typ=RST_PAR_TYP, prescale=RST_PRESCALE.
  - cfg_ack=0, rd_valid=0, rd_data=0, all counters 0.
  - FIFO emptied, config-pending flag cleared, FSM=IDLE.
  - Reset mid-frame or mid-config abandons that frame or config silently.
- Done event: set in a cycle where (rx_data_valid|rx_par_err|rx_stp_err)=1 and the same OR was 0 in the previous cycle. This is an edge detect, so level-held flags count once.
- Event classification:
  - rx_par_err and rx_stp_err each increment their own counter; both may increment together.
  - If rx_data_valid=1 with no error flag, the event is a push. If an error flag is present, the error wins and there is no push.
- FSM states:
  - IDLE: rx_in=0 -> BUSY, load watchdog with 12*prescale-1 (10-bit). Otherwise, if config is pending and rx_in=1 -> APPLY.
  - BUSY: done event -> IDLE. Watchdog reaches 0 with no event -> IDLE and tmo_cnt++. Otherwise the watchdog decrements.
  - APPLY: shadow registers copied to par_en/par_typ/prescale, cfg_ack=1 for this cycle only, pending cleared -> IDLE. Lasts exactly 1 cycle.
  - Done events seen in IDLE (late flags) are still classified and counted; they do not change state.
- Config handshake:
  - cfg_req latches cfg_* into shadow registers and sets pending, in any state.
  - A later cfg_req before apply overwrites the shadow; only one cfg_ack is issued, carrying the newest values.
  - In IDLE, rx_in=0 with pending set: the frame wins (-> BUSY) and the apply is deferred.
  - cfg_req in the same cycle as APPLY: APPLY uses the old shadow and the new request stays pending for the next apply.
  - Latency from cfg_req to outputs changing, line idle in IDLE: 2 cycles (latch, then APPLY).
  - Outputs never change while in BUSY.
- FIFO (first-word fall-through):
  - Push writes rx_p_data. Pop happens on rd_en & rd_valid.
  - Push and pop in the same cycle: both take effect; occupancy unchanged. When full, the push is accepted because a slot is freed.
  - Push when full with no pop: byte dropped, ovf_cnt++.
  - A pushed byte appears on rd_data/rd_valid the cycle after the push edge.
  - Pointers wrap modulo DEPTH; full/empty come from a log2(DEPTH)+1 occupancy counter.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr wins over a same-cycle increment (result 0).

Test Plan:
- Reset then idle line: par_en=1, par_typ=0, prescale=8, rd_valid=0, all counters 0, cfg_ack never asserted.
- Three good frames 0x09, 0xA5, 0x3C with no reads -> rd_valid=1, rd_data=0x09; pops return 0xA5 then 0x3C, then rd_valid=0.
- DEPTH=4, six good frames without reads -> FIFO holds first four bytes, ovf_cnt=2. Then pop one and push one in the same cycle -> occupancy stays 4, ovf_cnt unchanged.
- cfg_req {par_en=0, par_typ=1, prescale=16} asserted 20 cycles after a start bit at prescale 8 -> outputs unchanged until the done event. Then cfg_ack pulses once and outputs become 0/1/16 in the APPLY cycle.
- Frame with rx_par_err and rx_data_valid in the same cycle -> par_err_cnt=1, no push. Frame with rx_stp_err held high for 5 cycles -> stp_err_cnt increments by exactly 1.
- rx_in held low for 12*8+5 cycles with no flags -> tmo_cnt=1 and FSM returns to IDLE. Assert cnt_clr in the same cycle as a parity error -> par_err_cnt=0. Assert rst mid-BUSY -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver control wrapper: between-frame config apply, frame watchdog,
// FWFT byte FIFO and saturating error counters.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CNT_W        = 8,
   parameter bit          RST_PAR_EN   = 1'b1,
   parameter bit          RST_PAR_TYP  = 1'b0,
   parameter int unsigned RST_PRESCALE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_in,
   input  logic [7:0]       rx_p_data,
   input  logic             rx_data_valid,
   input  logic             rx_par_err,
   input  logic             rx_stp_err,
   input  logic             cfg_req,
   input  logic             cfg_par_en,
   input  logic             cfg_par_typ,
   input  logic [5:0]       cfg_prescale,
   output logic             cfg_ack,
   output logic             par_en,
   output logic             par_typ,
   output logic [5:0]       prescale,
   output logic             rd_valid,
   output logic [7:0]       rd_data,
   input  logic             rd_en,
   output logic [CNT_W-1:0] par_err_cnt,
   output logic [CNT_W-1:0] stp_err_cnt,
   output logic [CNT_W-1:0] ovf_cnt,
   output logic [CNT_W-1:0] tmo_cnt,
   input  logic             cnt_clr
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned WD_W = 10;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_APPLY} state_t;

   state_t            state_q, state_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              flag_q, flag_d;
   logic              pend_q, pend_d;
   logic              sh_par_en_q, sh_par_en_d;
   logic              sh_par_typ_q, sh_par_typ_d;
   logic [5:0]        sh_prescale_q, sh_prescale_d;
   logic              par_en_q, par_en_d;
   logic              par_typ_q, par_typ_d;
   logic [5:0]        prescale_q, prescale_d;
   logic              cfg_ack_q, cfg_ack_d;
   logic [7:0]        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              rd_valid_q, rd_valid_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic [CNT_W-1:0]  par_cnt_q, par_cnt_d;
   logic [CNT_W-1:0]  stp_cnt_q, stp_cnt_d;
   logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
   logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

   logic flag_or, done, push, pop, full, push_ok, tmo_inc, ovf_inc;

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic clr);
      if (clr) return '0;
      if (inc && (c != '1)) return c + CNT_W'(1);
      return c;
   endfunction

   // Next-state, config handshake, FIFO bookkeeping and counters
   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      pend_d        = pend_q;
      sh_par_en_d   = sh_par_en_q;
      sh_par_typ_d  = sh_par_typ_q;
      sh_prescale_d = sh_prescale_q;
      par_en_d      = par_en_q;
      par_typ_d     = par_typ_q;
      prescale_d    = prescale_q;
      cfg_ack_d     = 1'b0;
      tmo_inc       = 1'b0;
      rd_data_d     = rd_data_q;

      flag_or = rx_data_valid | rx_par_err | rx_stp_err;
      done    = flag_or & ~flag_q;
      flag_d  = flag_or;
      push    = done & rx_data_valid & ~rx_par_err & ~rx_stp_err;

      case (state_q)
         ST_IDLE: begin
            if (!rx_in) begin
               state_d = ST_BUSY;
               wdog_d  = WD_W'(prescale_q) * WD_W'(12) - WD_W'(1);
            end else if (pend_q) begin
               // New config lands on the outputs as APPLY is entered
               state_d    = ST_APPLY;
               par_en_d   = sh_par_en_q;
               par_typ_d  = sh_par_typ_q;
               prescale_d = sh_prescale_q;
               cfg_ack_d  = 1'b1;
               pend_d     = 1'b0;
            end
         end
         ST_BUSY: begin
            if (done) begin
               state_d = ST_IDLE;
            end else if (wdog_q == '0) begin
               state_d = ST_IDLE;
               tmo_inc = 1'b1;
            end else begin
               wdog_d = wdog_q - WD_W'(1);
            end
         end
         ST_APPLY: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (cfg_req) begin
         sh_par_en_d   = cfg_par_en;
         sh_par_typ_d  = cfg_par_typ;
         sh_prescale_d = cfg_prescale;
         pend_d        = 1'b1;
      end

      pop        = rd_en & rd_valid_q;
      full       = (count_q == CW'(DEPTH));
      push_ok    = push & (~full | pop);
      ovf_inc    = push & full & ~pop;
      wr_ptr_d   = wr_ptr_q + AW'(push_ok);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(push_ok) - CW'(pop);
      rd_valid_d = (count_d != '0);
      // The incoming byte becomes the head only when it lands where the head pointer goes
      if (push_ok && (wr_ptr_q == rd_ptr_d)) rd_data_d = rx_p_data;
      else if (count_d != '0)               rd_data_d = mem_q[rd_ptr_d];

      par_cnt_d = cnt_next(par_cnt_q, done & rx_par_err, cnt_clr);
      stp_cnt_d = cnt_next(stp_cnt_q, done & rx_stp_err, cnt_clr);
      ovf_cnt_d = cnt_next(ovf_cnt_q, ovf_inc, cnt_clr);
      tmo_cnt_d = cnt_next(tmo_cnt_q, tmo_inc, cnt_clr);
   end

   // State and control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         wdog_q        <= '0;
         flag_q        <= 1'b0;
         pend_q        <= 1'b0;
         sh_par_en_q   <= RST_PAR_EN;
         sh_par_typ_q  <= RST_PAR_TYP;
         sh_prescale_q <= 6'(RST_PRESCALE);
         par_en_q      <= RST_PAR_EN;
         par_typ_q     <= RST_PAR_TYP;
         prescale_q    <= 6'(RST_PRESCALE);
         cfg_ack_q     <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
         par_cnt_q     <= '0;
         stp_cnt_q     <= '0;
         ovf_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         flag_q        <= flag_d;
         pend_q        <= pend_d;
         sh_par_en_q   <= sh_par_en_d;
         sh_par_typ_q  <= sh_par_typ_d;
         sh_prescale_q <= sh_prescale_d;
         par_en_q      <= par_en_d;
         par_typ_q     <= par_typ_d;
         prescale_q    <= prescale_d;
         cfg_ack_q     <= cfg_ack_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         rd_valid_q    <= rd_valid_d;
         rd_data_q     <= rd_data_d;
         par_cnt_q     <= par_cnt_d;
         stp_cnt_q     <= stp_cnt_d;
         ovf_cnt_q     <= ovf_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   // FIFO storage needs no reset; occupancy decides what is visible
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rx_p_data;
   end

   assign cfg_ack     = cfg_ack_q;
   assign par_en      = par_en_q;
   assign par_typ     = par_typ_q;
   assign prescale    = prescale_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign par_err_cnt = par_cnt_q;
   assign stp_err_cnt = stp_cnt_q;
   assign ovf_cnt     = ovf_cnt_q;
   assign tmo_cnt     = tmo_cnt_q;

endmodule
